// File: rtl/bit_ser_operand_tx_if.sv
// Handshake/bus bundle for bit_ser_operand_tx: operand load, serial stream
// to the external adder, returned sum bit and assembled parallel result.
interface bit_ser_operand_tx_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             busy;
  logic             ser_a;
  logic             ser_b;
  logic             ser_valid;
  logic             ser_first;
  logic             sum_in;
  logic [WIDTH-1:0] result;
  logic             done;

  modport master (
    output start, op_a, op_b, sum_in,
    input  ready, busy, ser_a, ser_b,
    input  ser_valid, ser_first, result, done
  );

  modport slave (
    input  start, op_a, op_b, sum_in,
    output ready, busy, ser_a, ser_b,
    output ser_valid, ser_first, result, done
  );
endinterface

// File: rtl/bit_ser_operand_tx.sv
// Serialises two WIDTH-bit operands LSB first to a bit-serial adder and
// reassembles the one-cycle-latent returned sum into a parallel result.
// Ports: clk, clr (sync active-high), bus (slave side of the _if bundle).
module bit_ser_operand_tx #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 clr,
  bit_ser_operand_tx_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_ready;
  logic             r_busy;
  logic             r_valid;
  logic             r_first;
  logic             r_done;

  // Operand registers shift in zeros, so after WIDTH shifts the
  // serial bits read 0 in DRAIN without extra gating.
  assign bus.ser_a     = r_sa[0];
  assign bus.ser_b     = r_sb[0];
  assign bus.ser_valid = r_valid;
  assign bus.ser_first = r_first;
  assign bus.ready     = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_res;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sa    <= bus.op_a;
            r_sb    <= bus.op_b;
            r_cnt   <= '0;
            r_res   <= '0;
            r_state <= SHIFT;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_first <= 1'b1;
          end
        end
        SHIFT: begin
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_first <= 1'b0;
          // Sum bit k arrives one edge after bit k+1 is presented.
          if (r_cnt != '0) begin
            r_res <= {bus.sum_in, r_res[WIDTH-1:1]};
          end
          if (r_cnt == LAST) begin
            r_state <= DRAIN;
            r_valid <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DRAIN: begin
          r_res   <= {bus.sum_in, r_res[WIDTH-1:1]};
          r_cnt   <= '0;
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_first <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bit_ser_operand_tx.sv
// Self-checking bench for bit_ser_operand_tx with a looped-back
// behavioural serial adder; table-driven plus reset corner sequences.
module tb_bit_ser_operand_tx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  bit_ser_operand_tx_if #(.WIDTH(W)) bus ();

  bit_ser_operand_tx #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Registered serial adder; carry ignored on the first bit.
  logic carry;
  always @(posedge clk) begin
    if (clr) begin
      bus.sum_in <= 1'b0;
      carry      <= 1'b0;
    end else if (bus.ser_valid) begin
      bus.sum_in <= bus.ser_a ^ bus.ser_b ^ (carry & ~bus.ser_first);
      carry <= (bus.ser_a & bus.ser_b) |
               ((bus.ser_a ^ bus.ser_b) & carry & ~bus.ser_first);
    end else begin
      bus.sum_in <= 1'b0;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         hold;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[7];

  // Entered at a negedge with start=1 and operands applied, DUT idle.
  // Returns at the negedge of the done cycle.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp, input bit hold,
                         input string tag);
    logic [7:0] sa;
    logic [7:0] sb;
    int nfirst = 0;
    int nvalid = 0;
    int ndone  = 0;
    int nready = 0;
    sa = '0;
    sb = '0;
    chk({tag, " ready_at_accept"}, bus.ready, 1);
    @(posedge clk);
    for (int n = 0; n <= W + 1; n++) begin
      @(negedge clk);
      if (n == 0) begin
        if (!hold) bus.start = 1'b0;
        bus.op_a = ~a;
        bus.op_b = a ^ 8'h5A;
        chk({tag, " result_cleared"}, bus.result, 0);
      end
      if (n == W) bus.start = 1'b0;
      if (n < W) begin
        sa[n] = bus.ser_a;
        sb[n] = bus.ser_b;
        nfirst += int'(bus.ser_first);
        nvalid += int'(bus.ser_valid);
        ndone  += int'(bus.done);
        nready += int'(bus.ready);
      end else if (n == W) begin
        chk({tag, " drain v/a/b/busy/done"},
            {bus.ser_valid, bus.ser_a, bus.ser_b, bus.busy, bus.done},
            5'b00010);
      end else begin
        chk({tag, " done"}, bus.done, 1);
        chk({tag, " busy_in_done"}, bus.busy, 0);
        chk({tag, " ready_in_done"}, bus.ready, 1);
        chk({tag, " result"}, bus.result, exp);
      end
    end
    chk({tag, " stream_a"}, sa, a);
    chk({tag, " stream_b"}, sb, b);
    chk({tag, " first_count"}, nfirst, 1);
    chk({tag, " valid_count"}, nvalid, W);
    chk({tag, " early_done"}, ndone, 0);
    chk({tag, " ready_while_busy"}, nready, 0);
  endtask

  initial begin
    int nd;
    tbl[0] = '{8'd7,   8'd3,   1'b0, 8'h0A};
    tbl[1] = '{8'd6,   8'd4,   1'b0, 8'h0A};
    tbl[2] = '{8'd255, 8'd1,   1'b0, 8'h00};
    tbl[3] = '{8'h55,  8'hAA,  1'b0, 8'hFF};
    tbl[4] = '{8'h80,  8'h80,  1'b0, 8'h00};
    tbl[5] = '{8'h3C,  8'h0F,  1'b0, 8'h4B};
    tbl[6] = '{8'h12,  8'h34,  1'b1, 8'h46};

    clr = 1'b1;
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (2) @(negedge clk);
    chk("reset ready", bus.ready, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset valid/first/a/b",
        {bus.ser_valid, bus.ser_first, bus.ser_a, bus.ser_b}, 0);
    chk("reset done", bus.done, 0);
    chk("reset result", bus.result, 0);

    // clr wins over start at the same edge.
    bus.start = 1'b1;
    bus.op_a = 8'hFF;
    bus.op_b = 8'hFF;
    @(negedge clk);
    chk("clr_prio ready", bus.ready, 1);
    chk("clr_prio busy/valid", {bus.busy, bus.ser_valid}, 0);
    clr = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    // Back-to-back: next start is raised in each done cycle.
    for (int i = 0; i < 7; i++) begin
      bus.start = 1'b1;
      bus.op_a = tbl[i].a;
      bus.op_b = tbl[i].b;
      run_txn(tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].hold,
              $sformatf("vec%0d", i));
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("result_held", bus.result, 8'h46);
    chk("idle ready/done", {bus.ready, bus.done}, 2'b10);

    // Reset at E4 of a 7+3 transaction.
    bus.start = 1'b1;
    bus.op_a = 8'd7;
    bus.op_b = 8'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_clr busy", bus.busy, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("midclr ready", bus.ready, 1);
    chk("midclr busy", bus.busy, 0);
    chk("midclr serial outs",
        {bus.ser_valid, bus.ser_first, bus.ser_a, bus.ser_b}, 0);
    chk("midclr result", bus.result, 0);
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      nd += int'(bus.done) + int'(bus.busy);
    end
    chk("midclr no_done", nd, 0);

    bus.start = 1'b1;
    bus.op_a = 8'd7;
    bus.op_b = 8'd3;
    run_txn(8'd7, 8'd3, 8'h0A, 1'b0, "after_clr");
    @(negedge clk);
    chk("after_clr done_one_cycle", bus.done, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bit_ser_operand_tx.md
BIT_SER_OPERAND_TX -- requirements
Module: bit_ser_operand_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 clr  input  1  reset; synchronous and active-high; sampled on rising clk.
REQ-004 start  input  1  operand load request; qualified by ready.
REQ-005 op_a  input  WIDTH  parallel operand A; sampled only at the accept edge.
REQ-006 op_b  input  WIDTH  parallel operand B; sampled only at the accept edge.
REQ-007 ready  output  1  high when the block can accept start.
REQ-008 busy  output  1  high from the accept edge until the final sum capture.
REQ-009 ser_a  output  1  serial A bit, LSB first, to the bit-serial adder A input.
REQ-010 ser_b  output  1  serial B bit, LSB first, to the bit-serial adder B input.
REQ-011 ser_valid  output  1  high while ser_a/ser_b carry operand bits.
REQ-012 ser_first  output  1  high during bit 0 only; the adder uses it to clear carry.
REQ-013 sum_in  input  1  returned serial sum bit from the adder, LSB first.
REQ-014 result  output  WIDTH  parallel sum assembled from sum_in.
REQ-015 done  output  1  one-cycle pulse when result is complete.

Function
REQ-016 States SHALL be IDLE, SHIFT and DRAIN; ready=1 only in IDLE.
REQ-017 Accept edge E0 SHALL be a rising edge with state IDLE, start=1 and clr=0; op_a/op_b SHALL load into internal shift registers and the bit counter SHALL reset to 0 at E0.
REQ-018 After E0 the state SHALL be SHIFT, with busy=1, ser_valid=1, ser_first=1, ser_a=op_a[0] and ser_b=op_b[0].
REQ-019 After edge Ek (k=1..WIDTH-1), ser_a/ser_b SHALL present bit k and ser_first SHALL be 0.
REQ-020 All serial outputs SHALL be driven from registers, so no combinational path exists from inputs to outputs.
REQ-021 sum_in SHALL be treated as one-cycle latent: sum bit k SHALL be sampled at edge E(k+2), for k=0..WIDTH-1.
REQ-022 Sampled sum bits SHALL shift into result MSB-first from the top, so that after E(WIDTH+1) result[k] equals sum bit k.
REQ-023 At EWIDTH the state SHALL become DRAIN; ser_valid, ser_a and ser_b SHALL go to 0 and busy SHALL remain 1.
REQ-024 At E(WIDTH+1) the final bit SHALL be captured and the state SHALL become IDLE; in the following cycle done=1, busy=0 and ready=1.
REQ-025 Total latency from the accept edge to the done cycle SHALL be WIDTH+1 edges, i.e. 9 for WIDTH=8.
REQ-026 result SHALL hold its value until the next accept edge, and SHALL then clear to 0 at that edge.
REQ-027 start while busy SHALL be ignored, with no effect on any state, operand or counter.
REQ-028 A start during the done cycle SHALL be accepted, allowing back-to-back transactions with no idle gap.
REQ-029 Arithmetic is external to this block; result SHALL be exactly WIDTH bits and carry-out SHALL not be represented (modulo 2^WIDTH).
REQ-030 op_a/op_b changes after E0 SHALL NOT affect the stream in progress.

Reset
REQ-031 clr=1 at any edge, including mid-SHIFT or mid-DRAIN, SHALL force the state to IDLE.
REQ-032 After that reset edge: ready=1; busy, ser_valid, ser_first, ser_a, ser_b and done SHALL be 0; result SHALL be 0; the shift registers and counter SHALL be 0.
REQ-033 clr SHALL take priority over start at the same edge, and no transaction SHALL be accepted.
REQ-034 Any transaction interrupted by reset SHALL produce no done pulse.

Verification
REQ-035 Scenario: WIDTH=8, op_a=7, op_b=3, with a behavioural serial adder (registered sum, carry cleared on ser_first) looped to sum_in -> ser_a stream 1,1,1,0,0,0,0,0; ser_b stream 1,1,0,0,0,0,0,0; done 9 edges after accept; result=0x0A.
REQ-036 Scenario: op_a=6, op_b=4 issued in the done cycle of the previous transaction -> accepted with no gap; result=0x0A; ser_first pulses once per transaction.
REQ-037 Scenario: op_a=255, op_b=1 -> result=0x00 (wrap-around); done pulse length exactly 1 cycle.
REQ-038 Scenario: start held high throughout SHIFT with op_a/op_b changed mid-stream -> stream unchanged; exactly one done pulse per accepted transaction.
REQ-039 Scenario: clr=1 at E4 of a transaction -> next cycle IDLE, ready=1, all serial outputs 0, result=0, no done; a new 7+3 transaction then completes normally.
